// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage buses: imem req/ack and decoder valid/ready
interface instr_fetch_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic            dec_ready;
  logic [31:0]     instr;
  logic [5:0]      op;
  logic [5:0]      funct;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic            branch_taken;
  logic            jump;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, funct, pc, pc_plus4,
    input  imem_ack, imem_rdata, dec_ready, branch_taken, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, funct, pc, pc_plus4,
    output imem_ack, imem_rdata, dec_ready, branch_taken, jump
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, imem req/ack, decoder valid/ready, next-PC
// Define IFETCH_PERF_CNT_EN to build the retired-instruction and imem-stall counters.
module instr_fetch #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_if.master       bus,
  output logic [31:0]         instr_count,
  output logic [31:0]         stall_count
);
  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;
  logic            imem_req;
  logic            instr_valid;
  logic            consume;

  // Handshake outputs are masked in the reset cycle so nothing stale leaks out.
  assign imem_req    = (state_q == S_REQ) && !reset;
  assign instr_valid = (state_q == S_HOLD) && !reset;
  assign consume     = instr_valid && bus.dec_ready;

  assign pc_plus4      = pc_q + PC_W'(4);
  assign branch_target = pc_plus4 + {{(PC_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_target   = {pc_plus4[PC_W-1:28], instr_q[25:0], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_REQ: begin
        if (imem_req && bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = S_HOLD;
        end
      end
      default: begin
        if (consume) begin
          if (bus.jump)              pc_d = jump_target;
          else if (bus.branch_taken) pc_d = branch_target;
          else                       pc_d = pc_plus4;
          state_d = S_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    instr_count_d = instr_count_q + {31'd0, consume};
    stall_count_d = stall_count_q + {31'd0, imem_req && !bus.imem_ack};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif
endmodule
